// File: rtl/axi_burst_reader.sv
// AXI4 read master: turns a linear fetch command into 4 KB-safe INCR bursts
// and forwards the returned beats as an AXI-Stream with TLAST on the last beat.
module axi_burst_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_BURST_LEN = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // command
  input  logic [ADDR_WIDTH-1:0] s_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  s_cmd_len,
  input  logic [ID_WIDTH-1:0]   s_cmd_id,
  input  logic                  s_cmd_valid,
  output logic                  s_cmd_ready,
  // AXI4 read address channel
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // AXI4 read data channel
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  // AXI-Stream out
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  // status
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int SIZE_LOG2 = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [8:0]            beats_q, beats_d;
  logic [8:0]            burst_cnt_q, burst_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic [ADDR_WIDTH-1:0] accept_addr, next_addr;
  logic [8:0]            accept_beats, next_beats;
  logic                  beat_hs;

  // Burst size is the smallest of: what is left, the burst cap, and the beats
  // remaining before the next 4 KB page.
  function automatic logic [8:0] burst_beats(input logic [11:0] page_off,
                                             input logic [LEN_WIDTH-1:0] rem);
    int unsigned n;
    int unsigned to_4k;
    n     = 32'(rem);
    to_4k = 32'(13'd4096 - 13'(page_off)) >> SIZE_LOG2;
    if (n > MAX_BURST_LEN) n = MAX_BURST_LEN;
    if (n > to_4k) n = to_4k;
    return 9'(n);
  endfunction

  assign accept_addr  = s_cmd_addr & ALIGN_MASK;
  assign accept_beats = burst_beats(accept_addr[11:0], s_cmd_len);
  assign next_addr    = addr_q + (ADDR_WIDTH'(beats_q) << SIZE_LOG2);
  assign next_beats   = burst_beats(next_addr[11:0], rem_q - LEN_WIDTH'(1));

  // Read data passes straight through to the stream while a burst is open.
  assign m_axi_rready  = (state_q == DATA) && m_axis_tready;
  assign m_axis_tvalid = (state_q == DATA) && m_axi_rvalid;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tlast  = (state_q == DATA) && (rem_q == LEN_WIDTH'(1));
  assign beat_hs       = m_axis_tvalid && m_axis_tready;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    arvalid_d   = arvalid_q;
    addr_d      = addr_q;
    arlen_d     = arlen_q;
    id_d        = id_q;
    rem_d       = rem_q;
    beats_d     = beats_q;
    burst_cnt_d = burst_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (s_cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          error_d     = 1'b0;
          addr_d      = accept_addr;
          rem_d       = s_cmd_len;
          id_d        = s_cmd_id;
          if (s_cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = ADDR;
            arvalid_d = 1'b1;
            beats_d   = accept_beats;
            arlen_d   = 8'(accept_beats - 9'd1);
          end
        end
      end

      ADDR: begin
        if (m_axi_arready) begin
          arvalid_d   = 1'b0;
          state_d     = DATA;
          burst_cnt_d = beats_q;
        end
      end

      DATA: begin
        if (beat_hs) begin
          rem_d       = rem_q - LEN_WIDTH'(1);
          burst_cnt_d = burst_cnt_q - 9'd1;
          if (m_axi_rresp != 2'b00) error_d = 1'b1;
          if (burst_cnt_q == 9'd1) begin
            addr_d = next_addr;
            if (rem_q == LEN_WIDTH'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d   = ADDR;
              arvalid_d = 1'b1;
              beats_d   = next_beats;
              arlen_d   = 8'(next_beats - 9'd1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      addr_q      <= '0;
      arlen_q     <= '0;
      id_q        <= '0;
      rem_q       <= '0;
      beats_q     <= '0;
      burst_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      arvalid_q   <= arvalid_d;
      addr_q      <= addr_d;
      arlen_q     <= arlen_d;
      id_q        <= id_d;
      rem_q       <= rem_d;
      beats_q     <= beats_d;
      burst_cnt_q <= burst_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign s_cmd_ready   = cmd_ready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arid    = id_q;
  assign m_axi_arsize  = 3'(SIZE_LOG2);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

  // Beat counting is authoritative; RID and RLAST are deliberately ignored.
  logic unused_ok;
  assign unused_ok = ^{m_axi_rid, m_axi_rlast};

endmodule

// File: tb/tb_axi_burst_reader.sv
// Randomized bench for axi_burst_reader: an AXI RAM slave model plus a
// command-level reference model of burst splitting and the output stream.
module tb_axi_burst_reader;

  localparam int DW = 32, AW = 16, IW = 8, LW = 16, MBL = 256;
  localparam logic [12:0] FIXED_AR = {3'd2, 2'd1, 1'b0, 4'd3, 3'd0};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] s_cmd_addr = '0;
  logic [LW-1:0] s_cmd_len = '0;
  logic [IW-1:0] s_cmd_id = '0;
  logic          s_cmd_valid = 1'b0;
  logic          s_cmd_ready;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arlock;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [IW-1:0] m_axi_rid = '0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
  logic          m_axi_rlast = 1'b0;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          busy, done, error;

  always #5 clk = ~clk;

  axi_burst_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW), .MAX_BURST_LEN(MBL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len), .s_cmd_id(s_cmd_id),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .done(done), .error(error)
  );

  typedef struct { logic [15:0] addr; logic [7:0] len; logic [7:0] id; logic [12:0] fixed; } ar_t;
  typedef struct { logic [31:0] data; logic last; } beat_t;

  logic [31:0] mem [0:16383];
  ar_t         ar_q[$];
  beat_t       out_q[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0, last_beat_cyc = 0, done_cyc = 0, done_cnt = 0;
  int err_hs_cyc = -1, err_rise_cyc = -1;
  int viol = 0, err_beat = -1, tready_mode = 0, cmd_beats = 0;
  bit burst_active = 0, ar_wait = 0;
  logic [13:0] b_word = '0;
  logic [7:0]  b_id = '0;
  logic [31:0] ar_hold = '0;
  int b_left = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // RAM slave and bus monitor: observe at negedge, drive just after posedge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        burst_active = 0;
        b_left       = 0;
        ar_wait      = 0;
      end else begin
        if (m_axi_rready !== (burst_active ? m_axis_tready : 1'b0)) viol++;
        if (m_axis_tvalid !== (burst_active && m_axi_rvalid)) viol++;
        if (m_axi_arvalid && burst_active) viol++;
        if (ar_wait && (!m_axi_arvalid || {m_axi_araddr, m_axi_arlen, m_axi_arid} != ar_hold)) viol++;
        ar_wait = m_axi_arvalid && !m_axi_arready;
        ar_hold = {m_axi_araddr, m_axi_arlen, m_axi_arid};
        if (m_axis_tvalid && m_axis_tready) begin
          out_q.push_back('{m_axis_tdata, m_axis_tlast});
          last_beat_cyc = cyc;
          if (cmd_beats == err_beat) err_hs_cyc = cyc;
        end
        if (error && err_rise_cyc < 0) err_rise_cyc = cyc;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (m_axi_arvalid && m_axi_arready) begin
          ar_q.push_back('{m_axi_araddr, m_axi_arlen, m_axi_arid,
                           {m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot}});
          burst_active = 1;
          b_word = m_axi_araddr[15:2];
          b_id   = m_axi_arid;
          b_left = int'(m_axi_arlen) + 1;
        end
        if (m_axi_rvalid && m_axi_rready) begin
          cmd_beats++;
          b_word++;
          b_left--;
          if (b_left == 0) burst_active = 0;
        end
      end
      @(posedge clk);
      #1;
      // NOTE: testbench drives use blocking assignments placed #1 after the
      // edge, so the DUT never races the stimulus.
      if (!rst_n) begin
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
      end else begin
        m_axi_arready = ($urandom_range(0, 1) == 1);
        m_axi_rvalid  = burst_active && ($urandom_range(0, 3) != 0);
        m_axi_rdata   = mem[b_word];
        m_axi_rresp   = (cmd_beats == err_beat) ? 2'b10 : 2'b00;
        m_axi_rlast   = (b_left == 1);
        m_axi_rid     = b_id;
      end
      case (tready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(0, 1) == 1);
        default: m_axis_tready = (cyc % 3 == 0);
      endcase
    end
  end

  task automatic start_cmd(input logic [15:0] addr, input int len, input logic [7:0] id,
                           input int eb, input int mode);
    int k;
    @(posedge clk);
    #1;
    ar_q.delete();
    out_q.delete();
    viol = 0; done_cnt = 0; cmd_beats = 0; err_hs_cyc = -1;
    err_beat = eb; tready_mode = mode;
    s_cmd_addr = addr; s_cmd_len = 16'(len); s_cmd_id = id; s_cmd_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!s_cmd_ready && k < 50);
    check("cmd_ready", s_cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    s_cmd_valid  = 1'b0;
    err_rise_cyc = -1;
  endtask

  task automatic run_cmd(input logic [15:0] addr, input int len, input logic [7:0] id,
                         input int eb, input int mode);
    ar_t         exp_ar[$];
    logic [31:0] exp_d[$];
    int a, rem, b, k, busy_cnt, mism, tl_cnt, tl_idx;
    bit got_done;
    // Reference model: split the linear range by cap and page, then list words.
    a = int'(addr & 16'hFFFC);
    rem = len;
    while (rem > 0) begin
      b = rem;
      if (b > MBL) b = MBL;
      if (b > (4096 - a % 4096) / 4) b = (4096 - a % 4096) / 4;
      exp_ar.push_back('{16'(a), 8'(b - 1), id, FIXED_AR});
      a = (a + 4 * b) % 65536;
      rem -= b;
    end
    for (int i = 0; i < len; i++) exp_d.push_back(mem[(int'(addr >> 2) + i) % 16384]);

    start_cmd(addr, len, id, eb, mode);
    busy_cnt = 0; k = 0; got_done = 0;
    while (!got_done && k < 20000) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check("err_clear", error, 1'b0);
        check("arvalid_after_accept", m_axi_arvalid, len != 0);
      end
      if (busy) busy_cnt++;
      if (done) got_done = 1;
    end
    check("done_seen", got_done, 1'b1);
    check("busy_span", busy_cnt, (len == 0) ? 1 : k - 1);
    @(negedge clk);
    check("done_low", done, 1'b0);
    check("done_pulses", done_cnt, 1);
    check("ready_after_done", s_cmd_ready, 1'b1);
    check("error", error, eb >= 0 && eb < len);
    check("beats", out_q.size(), len);
    mism = 0; tl_cnt = 0; tl_idx = -1;
    foreach (out_q[i]) begin
      if (i < len && out_q[i].data !== exp_d[i]) mism++;
      if (out_q[i].last) begin
        tl_cnt++;
        tl_idx = i;
      end
    end
    check("data_mismatches", mism, 0);
    check("tlast_count", tl_cnt, (len > 0) ? 1 : 0);
    if (len > 0) begin
      check("tlast_pos", tl_idx, len - 1);
      check("done_latency", done_cyc - last_beat_cyc, 1);
    end
    if (eb >= 0 && eb < len) check("error_rise", err_rise_cyc - err_hs_cyc, 1);
    check("protocol_violations", viol, 0);
    check("ar_count", ar_q.size(), exp_ar.size());
    foreach (exp_ar[i]) begin
      if (i < ar_q.size()) begin
        check($sformatf("araddr%0d", i), ar_q[i].addr, exp_ar[i].addr);
        check($sformatf("arlen%0d", i), ar_q[i].len, exp_ar[i].len);
        check($sformatf("arid%0d", i), ar_q[i].id, exp_ar[i].id);
        check($sformatf("ar_fixed%0d", i), ar_q[i].fixed, exp_ar[i].fixed);
      end
    end
  endtask

  initial begin
    int k;
    foreach (mem[i]) mem[i] = $urandom;
    mem[16'h0100 >> 2] = 32'h0000_000A;
    mem[16'h0104 >> 2] = 32'h0000_000B;
    mem[16'h0108 >> 2] = 32'h0000_000C;
    mem[16'h010C >> 2] = 32'h0000_000D;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_cmd_ready", s_cmd_ready, 1'b0);
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_status", {busy, done, error}, 3'b000);
    check("rst_ar_payload", {m_axi_araddr, m_axi_arlen, m_axi_arid}, 32'h0);
    check("rst_stream", {m_axis_tvalid, m_axi_rready}, 2'b00);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_first_cycle", s_cmd_ready, 1'b0);
    @(negedge clk);
    check("ready_second_cycle", s_cmd_ready, 1'b1);

    run_cmd(16'h0100, 4, 8'h05, -1, 0);
    run_cmd(16'h0FF0, 8, 8'h11, -1, 1);
    run_cmd(16'h0000, 300, 8'h22, -1, 0);
    run_cmd(16'h0200, 4, 8'h33, -1, 2);
    run_cmd(16'h0300, 4, 8'h44, 1, 1);
    run_cmd(16'h0400, 0, 8'h55, -1, 0);
    run_cmd(16'hFFF2, 20, 8'h66, -1, 1);

    // Reset in the middle of a long command.
    start_cmd(16'h2000, 40, 8'h77, -1, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(out_q.size() >= 5 && m_axis_tvalid) && k < 2000);
    check("pre_reset_streaming", {busy, m_axis_tvalid}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_arvalid", m_axi_arvalid, 1'b0);
    check("midrst_tvalid", m_axis_tvalid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", s_cmd_ready, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("postrst_ready0", s_cmd_ready, 1'b0);
    @(negedge clk);
    check("postrst_ready1", s_cmd_ready, 1'b1);
    run_cmd(16'h1234, 10, 8'h88, -1, 1);

    for (int t = 0; t < 8; t++) begin
      logic [15:0] ra;
      int rl, reb, rmd;
      ra = 16'($urandom);
      if (t % 2 == 0) ra[11:8] = 4'hF;
      rl  = $urandom_range(0, 600);
      reb = (rl > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, rl - 1)) : -1;
      rmd = $urandom_range(0, 2);
      run_cmd(ra, rl, 8'($urandom), reb, rmd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
